composite_timing: RTL and testbench

- Line/frame sequencer for the composite video output path.
- Generates the `row_enable` and `vert_c` controls that the pixel generator consumes.
- Inserts horizontal sync, porch and vertical sync (broad-pulse) levels around the active picture.
- Muxes the pixel generator's 3-bit level code onto the DAC pins during active video only.
- Default timing: 262-line progressive NTSC-style frame at `sys_clk` = 27 MHz.

---
 rtl/composite_timing_if.sv | 32 +++
 rtl/composite_timing.sv | 141 ++++++++++++++
 tb/tb_composite_timing.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/composite_timing_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// composite_timing_if : pixel-path and timing-strobe bundle of composite_timing
// Rev 1.0
// ---------------------------------------------------------------------------
interface composite_timing_if;
  logic [2:0] pixel_in;
  logic       row_enable;
  logic [8:0] vert_c;
  logic [2:0] pixel_signal;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pixel_in,
    output row_enable,
    output vert_c,
    output pixel_signal,
    output line_start,
    output frame_start
  );

  modport slave (
    output pixel_in,
    input  row_enable,
    input  vert_c,
    input  pixel_signal,
    input  line_start,
    input  frame_start
  );
endinterface
`default_nettype wire

// File: rtl/composite_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// composite_timing : line/frame sequencer and sync/porch inserter for composite video
// Rev 1.0
// ---------------------------------------------------------------------------
module composite_timing #(
  parameter int H_TOTAL        = 1716,
  parameter int H_SYNC         = 127,
  parameter int H_BACK         = 127,
  parameter int H_ACTIVE       = 1404,
  parameter int V_TOTAL        = 262,
  parameter int V_SYNC         = 3,
  parameter int V_ACTIVE_START = 20,
  parameter int V_ACTIVE       = 240
) (
  input  wire logic           sys_clk,
  input  wire logic           sys_rst_n,
  composite_timing_if.master  vid
);

  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BACK_AT  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_AT   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_FRONT_AT = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  localparam logic [2:0] LVL_SYNC  = 3'b000;
  localparam logic [2:0] LVL_BLACK = 3'b001;

  typedef enum logic [1:0] {
    S_HSYNC  = 2'd0,
    S_BACK   = 2'd1,
    S_ACTIVE = 2'd2,
    S_FRONT  = 2'd3
  } hstate_e;

  // run_q holds the counters at (0,0) for the first edge after reset so that
  // edge presents line 0, h 0 rather than h 1.
  logic          run_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] line_q, line_d;
  hstate_e       state_q, state_d;
  logic          row_enable_q, row_enable_d;
  logic [8:0]    vert_c_q, vert_c_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          line_act_q, line_act_d;
  logic [2:0]    pixel_sig;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      line_q        <= '0;
      state_q       <= S_HSYNC;
      row_enable_q  <= 1'b0;
      vert_c_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      h_cnt_q       <= h_cnt_d;
      line_q        <= line_d;
      state_q       <= state_d;
      row_enable_q  <= row_enable_d;
      vert_c_q      <= vert_c_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    line_d  = line_q;
    if (!run_q) begin
      h_cnt_d = '0;
      line_d  = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      line_d  = (line_q == V_LAST) ? '0 : line_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = S_HSYNC;
    end else begin
      case (state_q)
        S_HSYNC:  if (h_cnt_d == H_BACK_AT)  state_d = S_BACK;
        S_BACK:   if (h_cnt_d == H_ACT_AT)   state_d = S_ACTIVE;
        S_ACTIVE: if (h_cnt_d == H_FRONT_AT) state_d = S_FRONT;
        S_FRONT:  if (h_cnt_d == '0)         state_d = S_HSYNC;
        default:                             state_d = S_HSYNC;
      endcase
    end
  end

  // Registered strobes are decoded from the next counter values so they line
  // up with the position the counters will hold after the edge.
  always_comb begin
    line_act_q    = (int'(line_q) >= V_ACTIVE_START) &&
                    (int'(line_q) <  V_ACTIVE_START + V_ACTIVE);
    line_act_d    = (int'(line_d) >= V_ACTIVE_START) &&
                    (int'(line_d) <  V_ACTIVE_START + V_ACTIVE);
    row_enable_d  = line_act_d && (state_d == S_ACTIVE);
    line_start_d  = (h_cnt_d == '0);
    frame_start_d = (h_cnt_d == '0) && (line_d == '0);
    vert_c_d      = vert_c_q;
    if (h_cnt_d == '0) begin
      vert_c_d = line_act_d ? 9'(int'(line_d) - V_ACTIVE_START) : 9'd0;
    end
  end

  // run_q is cleared asynchronously, so the DAC sees BLACK, not SYNC, during reset.
  always_comb begin
    pixel_sig = LVL_BLACK;
    if (!run_q) begin
      pixel_sig = LVL_BLACK;
    end else if (int'(line_q) < V_SYNC) begin
      pixel_sig = (int'(h_cnt_q) < H_TOTAL - H_SYNC) ? LVL_SYNC : LVL_BLACK;
    end else if (state_q == S_HSYNC) begin
      pixel_sig = LVL_SYNC;
    end else if (line_act_q && (state_q == S_ACTIVE)) begin
      pixel_sig = vid.pixel_in;
    end
  end

  assign vid.row_enable   = row_enable_q;
  assign vid.vert_c       = vert_c_q;
  assign vid.line_start   = line_start_q;
  assign vid.frame_start  = frame_start_q;
  assign vid.pixel_signal = pixel_sig;

endmodule
`default_nettype wire

// File: tb/tb_composite_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_composite_timing : directed self-checking bench for composite_timing
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_composite_timing;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;

  composite_timing_if vid();

  composite_timing #(
    .H_TOTAL(20), .H_SYNC(2), .H_BACK(3), .H_ACTIVE(12),
    .V_TOTAL(10), .V_SYNC(2), .V_ACTIVE_START(4), .V_ACTIVE(4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .vid       (vid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_reset();
    sys_rst_n    = 1'b0;
    vid.pixel_in = 3'b111;
    repeat (3) @(posedge sys_clk);
    #2;
    checks++; if (vid.pixel_signal !== 3'b001) begin errors++; $display("FAIL rst_pixel got %b exp 001", vid.pixel_signal); end
    checks++; if (vid.row_enable !== 1'b0) begin errors++; $display("FAIL rst_row_enable got %b exp 0", vid.row_enable); end
    checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL rst_vert_c got %0d exp 0", vid.vert_c); end
    checks++; if (vid.line_start !== 1'b0) begin errors++; $display("FAIL rst_line_start got %b exp 0", vid.line_start); end
    checks++; if (vid.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b exp 0", vid.frame_start); end
  endtask

  task automatic test_first_edge();
    sys_rst_n = 1'b1;
    tick();
    checks++; if (vid.frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b exp 1", vid.frame_start); end
    checks++; if (vid.line_start !== 1'b1) begin errors++; $display("FAIL first_line_start got %b exp 1", vid.line_start); end
    checks++; if (vid.pixel_signal !== 3'b000) begin errors++; $display("FAIL first_pixel got %b exp 000", vid.pixel_signal); end
  endtask

  // Lines 0-1: sync tip except the last two clocks (serration).
  task automatic test_vsync_lines();
    logic [2:0] exp_pix;
    for (int ln = 0; ln < 2; ln++) begin
      vid.pixel_in = 3'b111;
      #1;
      for (int h = 0; h < 20; h++) begin
        exp_pix = (h < 18) ? 3'b000 : 3'b001;
        checks++; if (vid.pixel_signal !== exp_pix) begin errors++; $display("FAIL vsync_pixel l%0d h%0d got %b exp %b", ln, h, vid.pixel_signal, exp_pix); end
        checks++; if (vid.row_enable !== 1'b0) begin errors++; $display("FAIL vsync_row_enable l%0d h%0d got %b exp 0", ln, h, vid.row_enable); end
        checks++; if (vid.line_start !== (h == 0)) begin errors++; $display("FAIL vsync_line_start l%0d h%0d got %b", ln, h, vid.line_start); end
        checks++; if (vid.frame_start !== (h == 0 && ln == 0)) begin errors++; $display("FAIL vsync_frame_start l%0d h%0d got %b", ln, h, vid.frame_start); end
        checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL vsync_vert_c l%0d h%0d got %0d exp 0", ln, h, vid.vert_c); end
        tick();
      end
    end
  endtask

  task automatic test_blank_lines();
    logic [2:0] exp_pix;
    for (int ln = 2; ln < 4; ln++) begin
      vid.pixel_in = 3'b101;
      #1;
      for (int h = 0; h < 20; h++) begin
        exp_pix = (h < 2) ? 3'b000 : 3'b001;
        checks++; if (vid.pixel_signal !== exp_pix) begin errors++; $display("FAIL blank_pixel l%0d h%0d got %b exp %b", ln, h, vid.pixel_signal, exp_pix); end
        checks++; if (vid.row_enable !== 1'b0) begin errors++; $display("FAIL blank_row_enable l%0d h%0d got %b exp 0", ln, h, vid.row_enable); end
        checks++; if (vid.line_start !== (h == 0)) begin errors++; $display("FAIL blank_line_start l%0d h%0d got %b", ln, h, vid.line_start); end
        checks++; if (vid.frame_start !== 1'b0) begin errors++; $display("FAIL blank_frame_start l%0d h%0d got %b exp 0", ln, h, vid.frame_start); end
        tick();
      end
    end
  endtask

  task automatic test_active_lines();
    logic [2:0] pins [4];
    logic [2:0] exp_pix;
    int         row_cnt;
    pins[0] = 3'b011; pins[1] = 3'b101; pins[2] = 3'b110; pins[3] = 3'b010;
    for (int ln = 4; ln < 8; ln++) begin
      vid.pixel_in = pins[ln-4];
      row_cnt = 0;
      #1;
      for (int h = 0; h < 20; h++) begin
        if (h < 2)       exp_pix = 3'b000;
        else if (h < 5)  exp_pix = 3'b001;
        else if (h < 17) exp_pix = pins[ln-4];
        else             exp_pix = 3'b001;
        if (vid.row_enable === 1'b1) row_cnt++;
        checks++; if (vid.pixel_signal !== exp_pix) begin errors++; $display("FAIL active_pixel l%0d h%0d got %b exp %b", ln, h, vid.pixel_signal, exp_pix); end
        checks++; if (vid.row_enable !== (h >= 5 && h <= 16)) begin errors++; $display("FAIL active_row_enable l%0d h%0d got %b", ln, h, vid.row_enable); end
        checks++; if (vid.vert_c !== 9'(ln - 4)) begin errors++; $display("FAIL active_vert_c l%0d h%0d got %0d exp %0d", ln, h, vid.vert_c, ln - 4); end
        checks++; if (vid.line_start !== (h == 0)) begin errors++; $display("FAIL active_line_start l%0d h%0d got %b", ln, h, vid.line_start); end
        tick();
      end
      checks++; if (row_cnt != 12) begin errors++; $display("FAIL active_row_count l%0d got %0d exp 12", ln, row_cnt); end
    end
  endtask

  task automatic test_blank_tail();
    logic [2:0] exp_pix;
    for (int ln = 8; ln < 10; ln++) begin
      vid.pixel_in = 3'b110;
      #1;
      for (int h = 0; h < 20; h++) begin
        exp_pix = (h < 2) ? 3'b000 : 3'b001;
        checks++; if (vid.pixel_signal !== exp_pix) begin errors++; $display("FAIL tail_pixel l%0d h%0d got %b exp %b", ln, h, vid.pixel_signal, exp_pix); end
        checks++; if (vid.pixel_signal === vid.pixel_in) begin errors++; $display("FAIL tail_pixel_leak l%0d h%0d got %b", ln, h, vid.pixel_signal); end
        checks++; if (vid.row_enable !== 1'b0) begin errors++; $display("FAIL tail_row_enable l%0d h%0d got %b exp 0", ln, h, vid.row_enable); end
        checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL tail_vert_c l%0d h%0d got %0d exp 0", ln, h, vid.vert_c); end
        checks++; if (vid.frame_start !== 1'b0) begin errors++; $display("FAIL tail_frame_start l%0d h%0d got %b exp 0", ln, h, vid.frame_start); end
        tick();
      end
    end
  endtask

  // 200 clocks after the first frame_start the frame wraps back to (0,0).
  task automatic test_frame_wrap();
    checks++; if (vid.frame_start !== 1'b1) begin errors++; $display("FAIL wrap_frame_start got %b exp 1", vid.frame_start); end
    checks++; if (vid.line_start !== 1'b1) begin errors++; $display("FAIL wrap_line_start got %b exp 1", vid.line_start); end
    checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL wrap_vert_c got %0d exp 0", vid.vert_c); end
    checks++; if (vid.pixel_signal !== 3'b000) begin errors++; $display("FAIL wrap_pixel got %b exp 000", vid.pixel_signal); end
    repeat (20) tick();
    checks++; if (vid.line_start !== 1'b1) begin errors++; $display("FAIL wrap_line1_start got %b exp 1", vid.line_start); end
    checks++; if (vid.frame_start !== 1'b0) begin errors++; $display("FAIL wrap_line1_frame got %b exp 0", vid.frame_start); end
  endtask

  task automatic test_async_reset();
    vid.pixel_in = 3'b111;
    repeat (89) tick();
    checks++; if (vid.row_enable !== 1'b1) begin errors++; $display("FAIL ar_pre_row_enable got %b exp 1", vid.row_enable); end
    checks++; if (vid.vert_c !== 9'd1) begin errors++; $display("FAIL ar_pre_vert_c got %0d exp 1", vid.vert_c); end
    checks++; if (vid.pixel_signal !== 3'b111) begin errors++; $display("FAIL ar_pre_pixel got %b exp 111", vid.pixel_signal); end
    #1 sys_rst_n = 1'b0;
    #1;
    checks++; if (vid.row_enable !== 1'b0) begin errors++; $display("FAIL ar_row_enable got %b exp 0", vid.row_enable); end
    checks++; if (vid.pixel_signal !== 3'b001) begin errors++; $display("FAIL ar_pixel got %b exp 001", vid.pixel_signal); end
    checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL ar_vert_c got %0d exp 0", vid.vert_c); end
    repeat (2) tick();
    checks++; if (vid.pixel_signal !== 3'b001) begin errors++; $display("FAIL ar_hold_pixel got %b exp 001", vid.pixel_signal); end
    checks++; if (vid.line_start !== 1'b0) begin errors++; $display("FAIL ar_hold_line_start got %b exp 0", vid.line_start); end
    sys_rst_n = 1'b1;
    tick();
    checks++; if (vid.frame_start !== 1'b1) begin errors++; $display("FAIL ar_restart_frame got %b exp 1", vid.frame_start); end
    checks++; if (vid.line_start !== 1'b1) begin errors++; $display("FAIL ar_restart_line got %b exp 1", vid.line_start); end
    checks++; if (vid.pixel_signal !== 3'b000) begin errors++; $display("FAIL ar_restart_pixel got %b exp 000", vid.pixel_signal); end
    checks++; if (vid.vert_c !== 9'd0) begin errors++; $display("FAIL ar_restart_vert_c got %0d exp 0", vid.vert_c); end
    tick();
    checks++; if (vid.line_start !== 1'b0) begin errors++; $display("FAIL ar_h1_line_start got %b exp 0", vid.line_start); end
    checks++; if (vid.pixel_signal !== 3'b000) begin errors++; $display("FAIL ar_h1_pixel got %b exp 000", vid.pixel_signal); end
    repeat (17) tick();
    checks++; if (vid.pixel_signal !== 3'b001) begin errors++; $display("FAIL ar_h18_pixel got %b exp 001", vid.pixel_signal); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_edge();
    test_vsync_lines();
    test_blank_lines();
    test_active_lines();
    test_blank_tail();
    test_frame_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
